tt_um_serial_ha_adder: RTL and testbench
========================================

# tt_um_serial_ha_adder

Bit-serial 4-bit adder controller that time-shares a single half-adder cell. It adds two operands and a carry-in over 2·OPW cycles, two half-adder passes per bit. It sits in the standard tiny-tapeout top-level wrapper, with operands on the dedicated inputs and result/status on the dedicated outputs. It is the sequenced successor to our combinational half-adder tile.

## Interface
- OPW, default 4: operand width in bits. Legal range 1..4, limited by the 8 dedicated input pins.
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- ena  in  1  power-good indication; ignored.
- ui_in  in  8  operand A = ui_in[3:0], operand B = ui_in[7:4]. Only the low OPW bits of each nibble are used.
- uio_in  in  8  [0] start, [1] abort, [2] cin; [7:3] unused.
- uo_out  out  8  [4:0] result (OPW+1 bits, zero-extended), [5] busy, [6] done, [7] constant 0.
- uio_out  out  8  constant 0.
- uio_oe  out  8  constant 0 (all bidirectional pins are inputs).

## Operation
- FSM states: IDLE, PASS1, PASS2, DONE.
- **IDLE**
  - If abort=0 and start=1: capture A, B, cin into shift registers a_sr, b_sr and carry register c; clear bit index i; go to PASS1.
  - Otherwise stay in IDLE.
- **PASS1**: half-adder inputs are (a_sr[0], b_sr[0]). Latch s1 = sum and c1 = carry. Go to PASS2.
- **PASS2**
  - Half-adder inputs are (s1, c). The sum is the result bit.
  - c ← c1 | carry_out.
  - Shift the result bit into an internal accumulator at the MSB end, then shift a_sr and b_sr right by one.
  - If i == OPW-1: output result register ← {c_next, accumulator}, go to DONE. Otherwise i ← i+1, go to PASS1.
- **DONE**: hold until start=0, then go to IDLE. start held high does not retrigger.
- **Abort**: abort=1 in PASS1 or PASS2 returns to IDLE on the next edge. The output result register is left unchanged and no done pulse is produced. Abort in DONE is ignored. In IDLE, abort has priority over start.
- **Output hold**: the result register changes only at PASS2 completion of the last bit. It holds its value across IDLE, DONE and aborted runs.
- **Flags**: busy = (state is PASS1 or PASS2); done = (state is DONE). Both are registered state decodes.
- **Arithmetic**: result = A + B + cin, exact in OPW+1 bits. No overflow is possible; maximum is 31 for OPW=4.
- **Reset values**: state IDLE, result 0, busy 0, done 0, all internal registers 0.

## Timing
- Let E0 be the edge that samples start=1 in IDLE.
- busy is high from E0+1 through the last PASS2.
- The result register and done both update at edge E0+2·OPW (E0+8 for OPW=4).
- Start-to-done latency is 2·OPW cycles. The minimum back-to-back period is 2·OPW+2 cycles: done must be seen, start dropped, then start raised again.
- Operand and cin pins are don't-care after E0. Changes mid-run do not affect the result.
- rst_n=0 sampled on any edge, in any state including mid-run, returns everything to reset values at that edge. Reset has priority over abort and start.

## Structure
- Shared package/include holds:
  - state encoding localparams: IDLE=2'd0, PASS1=2'd1, PASS2=2'd2, DONE=2'd3;
  - OPW default;
  - the uio_in bit-position constants START_BIT=0, ABORT_BIT=1, CIN_BIT=2.
- One sub-module: half_adder_cell. Inputs a, b; outputs sum=a^b, carry=a&b. Purely combinational, instantiated exactly once and muxed between PASS1 and PASS2 operands by state.
- The top wrapper ties off all unused inputs into a single _unused reduction wire.

## Test plan
- Reset, then A=9, B=5, cin=0, start pulse: busy rises at E0+1; done=1 and uo_out[4:0]=14 at E0+8; busy=0.
- A=15, B=15, cin=1: result 31, the carry propagates through all bits. Then A=0, B=0, cin=0: result 0 with no residual carry.
- Hold start high through DONE for 5 cycles: no restart and the result stays stable. Drop start: IDLE next edge, done=0.
- Run A=3, B=4 (result 7), then start A=10, B=6 and assert abort at E0+3: IDLE at E0+4, busy=0, done never asserts, result still 7.
- Assert rst_n=0 at E0+5 of a run: at that edge state is IDLE and uo_out=0. After release, a new start with A=1, B=2, cin=1 gives 4.
- Toggle ui_in and cin every cycle during a run of A=6, B=7, cin=0: result 13. Throughout all tests, uio_oe and uio_out stay 0 and uo_out[7] stays 0.

Source files
------------

// File: rtl/tt_um_serial_ha_adder_pkg.sv
// Shared constants for the bit-serial half-adder controller: FSM encoding,
// default operand width and uio_in control bit positions.
package tt_um_serial_ha_adder_pkg;

  localparam int OPW_DEFAULT = 4;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] PASS1 = 2'd1;
  localparam logic [1:0] PASS2 = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  localparam int START_BIT = 0;
  localparam int ABORT_BIT = 1;
  localparam int CIN_BIT   = 2;

endpackage

// File: rtl/tt_um_serial_ha_adder_if.sv
// Tiny-tapeout pin bundle: dedicated inputs/outputs and the bidirectional bank.
interface tt_um_serial_ha_adder_if;

  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  modport master (
    output ui_in,
    output uio_in,
    input  uo_out,
    input  uio_out,
    input  uio_oe
  );

  modport slave (
    input  ui_in,
    input  uio_in,
    output uo_out,
    output uio_out,
    output uio_oe
  );

endinterface

// File: rtl/tt_um_serial_ha_adder_half_adder_cell.sv
// The single shared half-adder cell; the controller time-multiplexes it.
module half_adder_cell (
  input  logic a,
  input  logic b,
  output logic sum,
  output logic carry
);

  assign sum   = a ^ b;
  assign carry = a & b;

endmodule

// File: rtl/tt_um_serial_ha_adder.sv
// Bit-serial adder: A + B + cin computed LSB-first, two half-adder passes per bit
// (operand pair, then partial sum with running carry).
module tt_um_serial_ha_adder
  import tt_um_serial_ha_adder_pkg::*;
#(
  parameter int OPW = OPW_DEFAULT
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     ena,
  tt_um_serial_ha_adder_if.slave   io
);

  logic [1:0]     state;
  logic [OPW-1:0] a_sr;
  logic [OPW-1:0] b_sr;
  logic [OPW-1:0] acc;
  logic [OPW:0]   result;
  logic [1:0]     idx;
  logic           c;
  logic           s1;
  logic           c1;

  logic start;
  logic abort;
  logic cin;
  assign start = io.uio_in[START_BIT];
  assign abort = io.uio_in[ABORT_BIT];
  assign cin   = io.uio_in[CIN_BIT];

  logic ha_a;
  logic ha_b;
  logic ha_sum;
  logic ha_carry;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    ha_a = a_sr[0];
    ha_b = b_sr[0];
    if (state == PASS2) begin
      ha_a = s1;
      ha_b = c;
    end
  end

  half_adder_cell u_ha (
    .a     (ha_a),
    .b     (ha_b),
    .sum   (ha_sum),
    .carry (ha_carry)
  );

  logic           c_next;
  logic [OPW:0]   acc_shift;
  logic           last_bit;
  assign c_next    = c1 | ha_carry;
  assign acc_shift = {ha_sum, acc};
  assign last_bit  = (idx == 2'(OPW - 1));

  // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      a_sr   <= '0;
      b_sr   <= '0;
      acc    <= '0;
      result <= '0;
      idx    <= '0;
      c      <= 1'b0;
      s1     <= 1'b0;
      c1     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (!abort && start) begin
            a_sr  <= io.ui_in[OPW-1:0];
            b_sr  <= io.ui_in[4 +: OPW];
            c     <= cin;
            idx   <= '0;
            state <= PASS1;
          end
        end
        PASS1: begin
          if (abort) begin
            state <= IDLE;
          end else begin
            s1    <= ha_sum;
            c1    <= ha_carry;
            state <= PASS2;
          end
        end
        PASS2: begin
          if (abort) begin
            state <= IDLE;
          end else begin
            c    <= c_next;
            acc  <= acc_shift[OPW:1];
            a_sr <= a_sr >> 1;
            b_sr <= b_sr >> 1;
            if (last_bit) begin
              result <= {c_next, acc_shift[OPW:1]};
              state  <= DONE;
            end else begin
              idx   <= idx + 2'd1;
              state <= PASS1;
            end
          end
        end
        DONE: begin
          // Level-sensitive release: a held start cannot retrigger a run.
          if (!start) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  logic busy;
  logic done;
  assign busy = (state == PASS1) || (state == PASS2);
  assign done = (state == DONE);

  assign io.uo_out  = {1'b0, done, busy, 5'(result)};
  assign io.uio_out = '0;
  assign io.uio_oe  = '0;

  wire _unused = &{1'b0, ena, io.ui_in, io.uio_in[7:3]};

endmodule

// File: tb/tb_tt_um_serial_ha_adder.sv
// Directed bench with a result scoreboard for the bit-serial half-adder controller.
module tb_tt_um_serial_ha_adder;

  logic clk = 1'b0;
  logic rst_n;
  logic ena;

  tt_um_serial_ha_adder_if io ();

  tt_um_serial_ha_adder dut (
    .clk   (clk),
    .rst_n (rst_n),
    .ena   (ena),
    .io    (io)
  );

  always #5 clk = ~clk;

  int tests_run = 0;
  int tests_failed = 0;
  logic [4:0] exp_q[$];

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests_run++;
    assert (obs === exp)
    else begin
      tests_failed++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle just past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_consts(input string tag);
    check({tag, " uio_oe"}, io.uio_oe, 8'd0);
    check({tag, " uio_out"}, io.uio_out, 8'd0);
    check({tag, " uo_out7"}, {7'd0, io.uo_out[7]}, 8'd0);
  endtask

  // Drive operands with start, take edge E0, and return just after it.
  task automatic start_op(input logic [3:0] a, input logic [3:0] b, input logic cin,
                          input bit hold, input bit push);
    io.ui_in  = {b, a};
    io.uio_in = {5'd0, cin, 1'b0, 1'b1};
    if (push) exp_q.push_back(5'(a) + 5'(b) + 5'(cin));
    step();
    if (!hold) io.uio_in[0] = 1'b0;
    check("busy after E0", {7'd0, io.uo_out[5]}, 8'd1);
  endtask

  // Wait (bounded) for done, check latency and pop the scoreboard on completion.
  task automatic wait_done(input string tag, input bit toggle);
    int n = 0;
    logic [4:0] exp;
    while (io.uo_out[6] !== 1'b1 && n < 20) begin
      if (toggle) begin
        io.ui_in      = 8'($urandom);
        io.uio_in[2]  = 1'($urandom);
      end
      step();
      n++;
    end
    check({tag, " latency"}, 8'(n), 8'd8);
    check({tag, " busy at done"}, {7'd0, io.uo_out[5]}, 8'd0);
    if (io.uo_out[6] === 1'b1) begin
      if (exp_q.size() == 0) begin
        check({tag, " scoreboard empty"}, 8'd1, 8'd0);
      end else begin
        exp = exp_q.pop_front();
        check({tag, " result"}, {3'd0, io.uo_out[4:0]}, {3'd0, exp});
      end
    end
    check_consts(tag);
  endtask

  task automatic release_start(input string tag);
    io.uio_in[0] = 1'b0;
    step();
    check({tag, " done cleared"}, {7'd0, io.uo_out[6]}, 8'd0);
  endtask

  initial begin
    bit saw_done;
    rst_n     = 1'b0;
    ena       = 1'b1;
    io.ui_in  = 8'd0;
    io.uio_in = 8'd0;
    repeat (3) step();
    check("reset uo_out", io.uo_out, 8'd0);
    check_consts("reset");
    rst_n = 1'b1;
    step();

    // Basic add with explicit timing checks around E0
    start_op(4'd9, 4'd5, 1'b0, 1'b0, 1'b1);
    check("9+5 done low after E0", {7'd0, io.uo_out[6]}, 8'd0);
    wait_done("9+5", 1'b0);
    release_start("9+5");

    // Full carry propagation, then all-zero with no residual carry
    start_op(4'd15, 4'd15, 1'b1, 1'b0, 1'b1);
    wait_done("15+15+1", 1'b0);
    release_start("15+15+1");
    start_op(4'd0, 4'd0, 1'b0, 1'b0, 1'b1);
    wait_done("0+0", 1'b0);
    release_start("0+0");

    // Start held high through DONE must not retrigger
    start_op(4'd2, 4'd11, 1'b1, 1'b1, 1'b1);
    wait_done("hold", 1'b0);
    for (int k = 0; k < 5; k++) begin
      step();
      check("hold done", {7'd0, io.uo_out[6]}, 8'd1);
      check("hold result", {3'd0, io.uo_out[4:0]}, 8'd14);
    end
    release_start("hold");
    check("hold busy after release", {7'd0, io.uo_out[5]}, 8'd0);

    // Abort mid-run keeps the previous result and never signals done
    start_op(4'd3, 4'd4, 1'b0, 1'b0, 1'b1);
    wait_done("3+4", 1'b0);
    release_start("3+4");
    start_op(4'd10, 4'd6, 1'b0, 1'b0, 1'b0);
    repeat (3) step();
    io.uio_in[1] = 1'b1;
    step();
    check("abort busy", {7'd0, io.uo_out[5]}, 8'd0);
    check("abort done", {7'd0, io.uo_out[6]}, 8'd0);
    check("abort result", {3'd0, io.uo_out[4:0]}, 8'd7);
    io.uio_in[1] = 1'b0;
    saw_done = 1'b0;
    for (int k = 0; k < 10; k++) begin
      step();
      if (io.uo_out[6] === 1'b1) saw_done = 1'b1;
    end
    check("abort no done", {7'd0, saw_done}, 8'd0);
    check("abort result held", {3'd0, io.uo_out[4:0]}, 8'd7);

    // Synchronous reset mid-run
    start_op(4'd12, 4'd3, 1'b0, 1'b0, 1'b0);
    repeat (4) step();
    rst_n = 1'b0;
    step();
    check("midrun reset uo_out", io.uo_out, 8'd0);
    rst_n = 1'b1;
    step();
    start_op(4'd1, 4'd2, 1'b1, 1'b0, 1'b1);
    wait_done("1+2+1", 1'b0);
    release_start("1+2+1");

    // Operand and cin pins toggling after E0 must not disturb the result
    start_op(4'd6, 4'd7, 1'b0, 1'b0, 1'b1);
    wait_done("toggle", 1'b1);
    release_start("toggle");

    check("scoreboard drained", 8'(exp_q.size()), 8'd0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
